// File: rtl/regfile_checker.sv
// Instruction-test sequencer: starts the core, waits a programmable run length, then
// scans the register file against an expected image. Optional masked compare: REGCHK_MASK_EN.
module regfile_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int INDEX_BITS = 5,
  parameter int RUN_BITS   = 16,
  parameter int COUNT_BITS = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  abort,
  input  logic [RUN_BITS-1:0]   run_cycles,
  output logic                  core_start,
  output logic [INDEX_BITS-1:0] rf_index,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
`ifdef REGCHK_MASK_EN
  input  logic [DATA_WIDTH-1:0] exp_mask,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic [COUNT_BITS-1:0] mismatch_count,
  output logic                  fail_valid,
  output logic [INDEX_BITS-1:0] fail_index,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_SCAN, S_DONE} state_e;

  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [RUN_BITS-1:0]   run_q, run_d;
  logic [RUN_BITS-1:0]   cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  passed_q, passed_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [INDEX_BITS-1:0] fail_index_q, fail_index_d;
  logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;
  logic                  mismatch;
  logic                  busy_w;

`ifdef REGCHK_MASK_EN
  assign mismatch = ((rf_data ^ exp_data) & exp_mask) != '0;
`else
  assign mismatch = rf_data != exp_data;
`endif

  // Status outputs decode straight from the state flop, so an async reset drops them at once.
  assign busy_w     = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_SCAN);
  assign busy       = busy_w;
  assign core_start = (state_q == S_LAUNCH);
  assign rf_index   = (state_q == S_SCAN) ? idx_q : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    done_d       = done_q;
    passed_d     = passed_q;
    count_d      = count_q;
    fail_valid_d = 1'b0;
    fail_index_d = fail_index_q;
    fail_exp_d   = fail_exp_q;
    fail_act_d   = fail_act_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go && !abort) begin
          state_d      = S_LAUNCH;
          run_d        = run_cycles;
          done_d       = 1'b0;
          passed_d     = 1'b0;
          count_d      = '0;
          fail_index_d = '0;
          fail_exp_d   = '0;
          fail_act_d   = '0;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = (run_q == '0) ? S_SCAN : S_RUN;
      end
      S_RUN: begin
        if (cnt_q == run_q - RUN_BITS'(1)) state_d = S_SCAN;
        else                               cnt_d   = cnt_q + RUN_BITS'(1);
      end
      S_SCAN: begin
        if (mismatch) begin
          fail_valid_d = 1'b1;
          if (count_q == '0) begin
            fail_index_d = idx_q;
            fail_exp_d   = exp_data;
            fail_act_d   = rf_data;
          end
          if (count_q != '1) count_d = count_q + COUNT_BITS'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          passed_d = (count_d == '0);
          idx_d    = '0;
        end else begin
          idx_d = idx_q + INDEX_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards everything gathered so far.
    if (abort && busy_w) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      idx_d        = '0;
      done_d       = 1'b0;
      passed_d     = 1'b0;
      count_d      = '0;
      fail_valid_d = 1'b0;
      fail_index_d = '0;
      fail_exp_d   = '0;
      fail_act_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      run_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      passed_q     <= 1'b0;
      count_q      <= '0;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
      fail_exp_q   <= '0;
      fail_act_q   <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      passed_q     <= passed_d;
      count_q      <= count_d;
      fail_valid_q <= fail_valid_d;
      fail_index_q <= fail_index_d;
      fail_exp_q   <= fail_exp_d;
      fail_act_q   <= fail_act_d;
    end
  end

  assign done           = done_q;
  assign passed         = passed_q;
  assign mismatch_count = count_q;
  assign fail_valid     = fail_valid_q;
  assign fail_index     = fail_index_q;
  assign fail_expected  = fail_exp_q;
  assign fail_actual    = fail_act_q;

endmodule
